// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 Hz timing constants and the coordinate type used by the
// vga_timing_gen block and its counters.
package vga_timing_pkg;

   typedef logic [9:0] coord_t;

   localparam coord_t H_ACTIVE = 10'd640;
   localparam coord_t H_FP     = 10'd16;
   localparam coord_t H_SYNC   = 10'd96;
   localparam coord_t H_BP     = 10'd48;
   localparam coord_t V_ACTIVE = 10'd480;
   localparam coord_t V_FP     = 10'd10;
   localparam coord_t V_SYNC   = 10'd2;
   localparam coord_t V_BP     = 10'd33;

   localparam coord_t H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam coord_t V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam coord_t H_MAX   = H_TOTAL - 10'd1;
   localparam coord_t V_MAX   = V_TOTAL - 10'd1;

   // Sync windows are half-open: [start, end)
   localparam coord_t H_SYNC_START = H_ACTIVE + H_FP;
   localparam coord_t H_SYNC_END   = H_SYNC_START + H_SYNC;
   localparam coord_t V_SYNC_START = V_ACTIVE + V_FP;
   localparam coord_t V_SYNC_END   = V_SYNC_START + V_SYNC;

   function automatic logic in_window(input coord_t c, input coord_t lo, input coord_t hi);
      return (c >= lo) && (c < hi);
   endfunction

endpackage

// File: rtl/vga_wrap_counter.sv
// Modulo-(MAX+1) counter that resets to MAX, so the first enabled edge after
// reset lands on 0. wrap flags that the coming edge rolls MAX over to 0.
module vga_wrap_counter
   import vga_timing_pkg::*;
#(
   parameter coord_t MAX = 10'd799
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       inc,
   output logic [9:0] cnt,
   output logic       wrap
);

   coord_t cnt_r;

   assign cnt  = cnt_r;
   assign wrap = inc && (cnt_r == MAX);

   // Count state: park at MAX in reset, roll over on wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= MAX;
      end else if (wrap) begin
         cnt_r <= 10'd0;
      end else if (inc) begin
         cnt_r <= cnt_r + 10'd1;
      end else begin
         cnt_r <= cnt_r;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 Hz VGA timing generator with look-ahead coordinates.
// Optional build macro VGA_FRAME_CNT_EN adds a 16-bit frame counter output.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int LOOKAHEAD = 32'sd2
) (
   input  logic        clk_25MHz,
   input  logic        rst,
   output logic [9:0]  h_cnt,
   output logic [9:0]  v_cnt,
   output logic [9:0]  ah_cnt,
   output logic [9:0]  av_cnt,
   output logic        valid,
   output logic        hsync,
   output logic        vsync,
   output logic        line_start,
   output logic        frame_start
`ifdef VGA_FRAME_CNT_EN
   ,
   output logic [15:0] frame_cnt
`endif
);

   localparam logic [10:0] LA_W      = 11'(LOOKAHEAD);
   localparam logic [10:0] H_TOTAL_W = {1'b0, H_TOTAL};
   localparam coord_t      AH_RST    = (LOOKAHEAD == 32'sd0) ? H_MAX : coord_t'(LOOKAHEAD - 32'sd1);
   localparam coord_t      AV_RST    = (LOOKAHEAD == 32'sd0) ? V_MAX : 10'd0;

   coord_t      h_cnt_s, v_cnt_s;
   logic        h_wrap_s, v_wrap_s;
   coord_t      h_nxt_s, v_nxt_s;
   coord_t      ah_nxt_s, av_nxt_s;
   logic [10:0] ah_sum_s;
   logic        fs_nxt_s;

   vga_wrap_counter #(.MAX(H_MAX)) u_h_cnt (
      .clk  (clk_25MHz),
      .rst  (rst),
      .inc  (1'b1),
      .cnt  (h_cnt_s),
      .wrap (h_wrap_s)
   );

   vga_wrap_counter #(.MAX(V_MAX)) u_v_cnt (
      .clk  (clk_25MHz),
      .rst  (rst),
      .inc  (h_wrap_s),
      .cnt  (v_cnt_s),
      .wrap (v_wrap_s)
   );

   assign h_cnt = h_cnt_s;
   assign v_cnt = v_cnt_s;

   // Mirror the counters' next state so every decoded output lines up with them.
   always_comb begin
      h_nxt_s  = h_wrap_s ? 10'd0 : (h_cnt_s + 10'd1);
      v_nxt_s  = v_wrap_s ? 10'd0 : (h_wrap_s ? (v_cnt_s + 10'd1) : v_cnt_s);
      fs_nxt_s = (h_nxt_s == 10'd0) && (v_nxt_s == 10'd0);
      ah_sum_s = {1'b0, h_nxt_s} + LA_W;
      if (ah_sum_s >= H_TOTAL_W) begin
         ah_nxt_s = coord_t'(ah_sum_s - H_TOTAL_W);
         av_nxt_s = (v_nxt_s == V_MAX) ? 10'd0 : (v_nxt_s + 10'd1);
      end else begin
         ah_nxt_s = ah_sum_s[9:0];
         av_nxt_s = v_nxt_s;
      end
   end

   // Decoded outputs registered from next-state coordinates.
   always_ff @(posedge clk_25MHz) begin
      if (rst) begin
         ah_cnt      <= AH_RST;
         av_cnt      <= AV_RST;
         valid       <= 1'b0;
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         ah_cnt      <= ah_nxt_s;
         av_cnt      <= av_nxt_s;
         valid       <= (h_nxt_s < H_ACTIVE) && (v_nxt_s < V_ACTIVE);
         hsync       <= !in_window(h_nxt_s, H_SYNC_START, H_SYNC_END);
         vsync       <= !in_window(v_nxt_s, V_SYNC_START, V_SYNC_END);
         line_start  <= (h_nxt_s == 10'd0);
         frame_start <= fs_nxt_s;
      end
   end

`ifdef VGA_FRAME_CNT_EN
   logic [15:0] frame_cnt_r;

   assign frame_cnt = frame_cnt_r;

   // Frame counter steps on the edge that raises frame_start.
   always_ff @(posedge clk_25MHz) begin
      if (rst) begin
         frame_cnt_r <= 16'd0;
      end else if (fs_nxt_s) begin
         frame_cnt_r <= frame_cnt_r + 16'd1;
      end else begin
         frame_cnt_r <= frame_cnt_r;
      end
   end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: a linear pixel-index model checked
// every cycle, plus hand-computed literal checks at the interesting positions.
module tb_vga_timing_gen;

   localparam int LA      = 2;
   localparam int HT      = 800;
   localparam int VT      = 525;
   localparam int FRAME   = HT * VT;

   logic       clk_25MHz = 1'b0;
   logic       rst       = 1'b1;
   logic [9:0] h_cnt, v_cnt, ah_cnt, av_cnt;
   logic       valid, hsync, vsync, line_start, frame_start;
`ifdef VGA_FRAME_CNT_EN
   logic [15:0] frame_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Model: linear position within the frame; reset parks it on the last pixel.
   int          pos        = FRAME - 1;
   logic        model_live = 1'b0;
   logic [15:0] fc_m       = 16'd0;
   logic [9:0]  jump_h, jump_v;

   vga_timing_gen #(.LOOKAHEAD(LA)) dut (
      .clk_25MHz   (clk_25MHz),
      .rst         (rst),
      .h_cnt       (h_cnt),
      .v_cnt       (v_cnt),
      .ah_cnt      (ah_cnt),
      .av_cnt      (av_cnt),
      .valid       (valid),
      .hsync       (hsync),
      .vsync       (vsync),
      .line_start  (line_start),
      .frame_start (frame_start)
`ifdef VGA_FRAME_CNT_EN
      ,
      .frame_cnt   (frame_cnt)
`endif
   );

   always #5 clk_25MHz = ~clk_25MHz;

   function automatic logic [44:0] exp_vec(input int p);
      int h, v, a;
      logic [9:0] hh, vv, aah, aav;
      logic vl, hs, vs, ls, fs;
      h   = p % HT;
      v   = p / HT;
      a   = (p + LA) % FRAME;
      hh  = 10'(h);
      vv  = 10'(v);
      aah = 10'(a % HT);
      aav = 10'(a / HT);
      vl  = (h < 640) && (v < 480);
      hs  = !((h >= 656) && (h < 752));
      vs  = !((v >= 490) && (v < 492));
      ls  = (h == 0);
      fs  = (p == 0);
      return {hh, vv, aah, aav, vl, hs, vs, ls, fs};
   endfunction

   // Advance the model on every edge.
   always @(posedge clk_25MHz) begin
      if (rst) begin
         pos  = FRAME - 1;
         fc_m = 16'd0;
      end else begin
         pos = (pos + 1) % FRAME;
         if (pos == 0) fc_m = fc_m + 16'd1;
      end
      model_live = 1'b1;
   end

   // Compare all outputs against the model once per cycle.
   always @(negedge clk_25MHz) begin
      logic [44:0] got, exp;
      if (model_live) begin
         got = {h_cnt, v_cnt, ah_cnt, av_cnt, valid, hsync, vsync, line_start, frame_start};
         exp = exp_vec(pos);
         n_checks++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL model_cycle pos=%0d got=%h expected=%h", pos, got, exp);
         end
`ifdef VGA_FRAME_CNT_EN
         n_checks++;
         if (frame_cnt !== fc_m) begin
            n_fail++;
            $display("FAIL model_frame_cnt pos=%0d got=%0d expected=%0d", pos, frame_cnt, fc_m);
         end
`endif
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk_25MHz);
      #1;
   endtask

   // Teleport the counters to (jump_h, jump_v) between edges; the model follows.
   task jump(input int h, input int v);
      jump_h = 10'(h);
      jump_v = 10'(v);
      force dut.u_h_cnt.cnt_r = jump_h;
      force dut.u_v_cnt.cnt_r = jump_v;
      #1;
      release dut.u_h_cnt.cnt_r;
      release dut.u_v_cnt.cnt_r;
      pos = v * HT + h;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_low, hits, found;

      rst = 1'b1;
      repeat (3) tick();
      chk("rst_h", h_cnt, 799);
      chk("rst_v", v_cnt, 524);
      chk("rst_ah", ah_cnt, 1);
      chk("rst_av", av_cnt, 0);
      chk("rst_valid", valid, 0);
      chk("rst_hsync", hsync, 1);
      chk("rst_vsync", vsync, 1);
      chk("rst_ls", line_start, 0);
      chk("rst_fs", frame_start, 0);
`ifdef VGA_FRAME_CNT_EN
      chk("rst_fcnt", frame_cnt, 0);
`endif

      rst = 1'b0;
      tick();
      chk("first_h", h_cnt, 0);
      chk("first_v", v_cnt, 0);
      chk("first_valid", valid, 1);
      chk("first_ls", line_start, 1);
      chk("first_fs", frame_start, 1);
      chk("first_ah", ah_cnt, 2);
      chk("first_av", av_cnt, 0);
`ifdef VGA_FRAME_CNT_EN
      chk("first_fcnt", frame_cnt, 1);
`endif

      // Line 100: active edge and hsync window.
      jump(630, 100);
      n_low = 0;
      hits  = 0;
      for (int i = 0; i < HT; i++) begin
         tick();
         if (hsync == 1'b0) n_low++;
         if (v_cnt == 10'd100) begin
            if (h_cnt == 10'd639) begin chk("valid_639", valid, 1); hits++; end
            if (h_cnt == 10'd640) begin chk("valid_640", valid, 0); hits++; end
            if (h_cnt == 10'd655) begin chk("hsync_655", hsync, 1); hits++; end
            if (h_cnt == 10'd752) begin chk("hsync_752", hsync, 1); hits++; end
         end
      end
      chk("hsync_low_cycles", n_low, 96);
      chk("line100_points", hits, 4);

      // Line wrap look-ahead.
      jump(796, 10);
      tick();
      tick();
      chk("lw798_h", h_cnt, 798);
      chk("lw798_ah", ah_cnt, 0);
      chk("lw798_av", av_cnt, 11);
      tick();
      chk("lw799_ah", ah_cnt, 1);
      chk("lw799_av", av_cnt, 11);
      tick();
      chk("lw_next_h", h_cnt, 0);
      chk("lw_next_v", v_cnt, 11);
      chk("lw_next_ls", line_start, 1);
      chk("lw_next_fs", frame_start, 0);

      // Vsync spans exactly two whole lines.
      jump(0, 488);
      n_low = 0;
      for (int i = 0; i < 6 * HT; i++) begin
         tick();
         if (vsync == 1'b0) n_low++;
      end
      chk("vsync_low_cycles", n_low, 1600);

      // Frame wrap.
      jump(797, 524);
      tick();
      tick();
      chk("fw_h", h_cnt, 799);
      chk("fw_v", v_cnt, 524);
      chk("fw_av", av_cnt, 0);
      tick();
      chk("fw_next_h", h_cnt, 0);
      chk("fw_next_v", v_cnt, 0);
      chk("fw_next_fs", frame_start, 1);
`ifdef VGA_FRAME_CNT_EN
      chk("fw_fcnt", frame_cnt, 2);
`endif

      // Mid-frame reset at (300,200).
      jump(290, 200);
      found = 0;
      for (int i = 0; i < 50 && found == 0; i++) begin
         if (h_cnt == 10'd300 && v_cnt == 10'd200) found = 1;
         else tick();
      end
      chk("reach_300_200", found, 1);
      rst = 1'b1;
      tick();
      chk("mrst_h", h_cnt, 799);
      chk("mrst_v", v_cnt, 524);
      chk("mrst_valid", valid, 0);
      chk("mrst_hsync", hsync, 1);
      chk("mrst_vsync", vsync, 1);
      rst = 1'b0;
      tick();
      chk("mrst_next_h", h_cnt, 0);
      chk("mrst_next_v", v_cnt, 0);
      chk("mrst_next_fs", frame_start, 1);

`ifdef VGA_FRAME_CNT_EN
      // Frame counter rollover.
      force dut.frame_cnt_r = 16'hFFFF;
      jump(797, 524);
      release dut.frame_cnt_r;
      fc_m = 16'hFFFF;
      repeat (3) tick();
      chk("fcnt_wrap_fs", frame_start, 1);
      chk("fcnt_wrap", frame_cnt, 0);
`endif

      repeat (20) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
